// File: rtl/packet_arbiter.sv
// Round-robin N-to-1 merge point: the winning input is enqueued into a small FIFO
// that drains on a single val/rdy output stream. Messages pass through untouched.
module packet_arbiter #(
   parameter int unsigned nbits    = 32,
   parameter int unsigned ninputs  = 8,
   parameter int unsigned nentries = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             istream_val [0:ninputs-1],
   input  logic [nbits-1:0] istream_msg [0:ninputs-1],
   output logic             istream_rdy [0:ninputs-1],
   output logic             ostream_val,
   output logic [nbits-1:0] ostream_msg,
   input  logic             ostream_rdy
);

   localparam int unsigned ptr_w  = $clog2(ninputs);
   localparam int unsigned addr_w = $clog2(nentries);
   localparam int unsigned cnt_w  = $clog2(nentries + 1);

   logic [ptr_w-1:0]   prio_q, prio_d, gnt_ptr;
   logic [addr_w-1:0]  rd_ptr_q, wr_ptr_q, rd_ptr_nxt, wr_ptr_nxt;
   logic [cnt_w-1:0]   count_q, count_d;
   logic [nbits-1:0]   mem_q [0:nentries-1];
   logic [ninputs-1:0] req, gnt_oh;
   logic [nbits-1:0]   enq_msg;
   logic               space, found, enq, deq;

   // Space comes from the registered count only, so ostream_rdy never reaches istream_rdy.
   assign space       = (count_q < cnt_w'(nentries));
   assign enq         = found & space;
   assign ostream_val = (count_q != '0);
   assign deq         = ostream_val & ostream_rdy;
   assign ostream_msg = mem_q[rd_ptr_q];

   always_comb begin
      req     = '0;
      gnt_oh  = '0;
      gnt_ptr = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < ninputs; i++) begin
         req[i] = istream_val[i];
      end
      // First pass covers inputs at or above the pointer, second pass wraps to the rest.
      for (int unsigned i = 0; i < ninputs; i++) begin
         if (!found && req[i] && (ptr_w'(i) >= prio_q)) begin
            found     = 1'b1;
            gnt_oh[i] = 1'b1;
            gnt_ptr   = ptr_w'(i);
         end
      end
      for (int unsigned i = 0; i < ninputs; i++) begin
         if (!found && req[i]) begin
            found     = 1'b1;
            gnt_oh[i] = 1'b1;
            gnt_ptr   = ptr_w'(i);
         end
      end
   end

   always_comb begin
      enq_msg = '0;
      for (int unsigned i = 0; i < ninputs; i++) begin
         istream_rdy[i] = gnt_oh[i] & space & reset;
         if (gnt_oh[i]) begin
            enq_msg = istream_msg[i];
         end
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (enq) begin
         prio_d = (gnt_ptr == ptr_w'(ninputs - 1)) ? '0 : gnt_ptr + ptr_w'(1);
      end
   end

   assign wr_ptr_nxt = (wr_ptr_q == addr_w'(nentries - 1)) ? '0 : wr_ptr_q + addr_w'(1);
   assign rd_ptr_nxt = (rd_ptr_q == addr_w'(nentries - 1)) ? '0 : rd_ptr_q + addr_w'(1);

   always_comb begin
      count_d = count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + cnt_w'(1);
         2'b01:   count_d = count_q - cnt_w'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q   <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         prio_q  <= prio_d;
         count_q <= count_d;
         if (enq) begin
            wr_ptr_q <= wr_ptr_nxt;
         end
         if (deq) begin
            rd_ptr_q <= rd_ptr_nxt;
         end
      end
   end

   // Storage needs no reset; ostream_val masks stale entries.
   always_ff @(posedge clk) begin
      if (enq && reset) begin
         mem_q[wr_ptr_q] <= enq_msg;
      end
   end

endmodule
